// File: rtl/addsub_pkg.sv
// addsub_pkg
// Shared types and helpers for the pipelined adder/subtractor.
//   addsub_flags_t : registered result flags {cout, ovf, zero}
//   chunk_add      : MAX_CHUNK-wide add with carry-in, returns {cout, sum}.
//                    Narrower chunks zero-extend into it and take the carry
//                    from bit CHUNK of the result.
package addsub_pkg;

  localparam int MAX_CHUNK = 64;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } addsub_flags_t;

  function automatic logic [MAX_CHUNK:0] chunk_add(
    input logic [MAX_CHUNK-1:0] a,
    input logic [MAX_CHUNK-1:0] b,
    input logic                 cin
  );
    chunk_add = {1'b0, a} + {1'b0, b} + {{MAX_CHUNK{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice
// Combinational CHUNK-bit adder used by one pipeline stage.
//   a, b   : chunk operands (b already conditioned for subtraction)
//   cin    : carry into the chunk
//   sum    : chunk sum
//   cout   : carry out of the chunk
//   c_msb  : carry into the top bit of the chunk (for signed overflow)
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [MAX_CHUNK:0] raw;
  logic               unused_raw;

  // Operands are zero-extended, so the chunk carry lands in bit CHUNK.
  assign raw  = chunk_add(MAX_CHUNK'(a), MAX_CHUNK'(b), cin);
  assign sum  = raw[CHUNK-1:0];
  assign cout = raw[CHUNK];

  // The sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out
  // of the same XOR without a second adder.
  assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

  assign unused_raw = ^raw;

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe
// Pipelined two's-complement adder/subtractor. WIDTH bits are split into
// STAGES chunks; stage k adds chunk k using the carry registered by stage
// k-1. Upper operand chunks ride along in skew registers and finished lower
// sum chunks ride along in deskew registers, so the whole result and its
// flags leave the last stage together, STAGES cycles after acceptance.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_valid / o_ready       : input handshake
//   i_a, i_b, i_sub         : operands, 1 = A-B, 0 = A+B
//   o_valid / i_ready       : output handshake
//   o_sum                   : result modulo 2^WIDTH
//   o_cout                  : carry (add) or borrow (sub)
//   o_ovf, o_zero           : signed overflow, result is zero
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int CHUNK = WIDTH / STAGES;

  if ((WIDTH % STAGES) != 0) begin : g_bad_split
    $error("addsub_pipe: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end
  if (CHUNK > MAX_CHUNK) begin : g_bad_chunk
    $error("addsub_pipe: chunk width %0d exceeds MAX_CHUNK %0d", CHUNK, MAX_CHUNK);
  end

  logic             valid_q [STAGES];
  logic             sub_q   [STAGES];
  logic             carry_q [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [STAGES-1:0] slice_msb;
  addsub_flags_t    flags_q;

  logic stall;
  logic advance;
  logic unused_tail;

  // A result sitting at the output that nobody takes freezes the whole
  // pipeline; otherwise every stage shifts, bubbles included.
  assign stall   = valid_q[STAGES-1] & ~i_ready;
  assign advance = ~stall;
  assign o_ready = ~stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] sum_next;
    logic             cin;
    logic             sub_in;
    logic             valid_in;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;

    if (k == 0) begin : g_first
      // Subtraction is A + ~B + 1: invert B up front and feed sub as c0.
      assign a_in     = i_a;
      assign b_in     = i_b ^ {WIDTH{i_sub}};
      assign sum_in   = '0;
      assign cin      = i_sub;
      assign sub_in   = i_sub;
      assign valid_in = i_valid;
    end else begin : g_next
      assign a_in     = a_q[k-1];
      assign b_in     = b_q[k-1];
      assign sum_in   = sum_q[k-1];
      assign cin      = carry_q[k-1];
      assign sub_in   = sub_q[k-1];
      assign valid_in = valid_q[k-1];
    end

    addsub_slice #(.CHUNK(CHUNK)) u_slice (
      .a     (a_in[k*CHUNK +: CHUNK]),
      .b     (b_in[k*CHUNK +: CHUNK]),
      .cin   (cin),
      .sum   (chunk_sum),
      .cout  (chunk_cout),
      .c_msb (slice_msb[k])
    );

    always_comb begin
      sum_next = sum_in;
      sum_next[k*CHUNK +: CHUNK] = chunk_sum;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        valid_q[k] <= 1'b0;
        sub_q[k]   <= 1'b0;
        carry_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
      end else if (advance) begin
        valid_q[k] <= valid_in;
        sub_q[k]   <= sub_in;
        carry_q[k] <= chunk_cout;
        a_q[k]     <= a_in;
        b_q[k]     <= b_in;
        sum_q[k]   <= sum_next;
      end
    end

    if (k == STAGES-1) begin : g_flags
      // Flags come from the final carry c_W and the carry into the MSB
      // c_{W-1}; they are registered so they reset to 0 like o_sum.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          flags_q <= '0;
        end else if (advance) begin
          flags_q.cout <= chunk_cout ^ sub_in;
          flags_q.ovf  <= chunk_cout ^ slice_msb[k];
          flags_q.zero <= ~|sum_next;
        end
      end
    end
  end

  assign o_valid = valid_q[STAGES-1];
  assign o_sum   = sum_q[STAGES-1];
  assign o_cout  = flags_q.cout;
  assign o_ovf   = flags_q.ovf;
  assign o_zero  = flags_q.zero;

  // The last stage's skew/carry copies have no consumer.
  assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1], carry_q[STAGES-1],
                         sub_q[STAGES-1], slice_msb};

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe
// Self-checking bench for addsub_pipe (WIDTH=32, STAGES=4): a table of
// directed vectors with latency checks, backpressure, reset mid-stream and
// a long randomised run, all cross-checked by an in-order scoreboard.
module tb_addsub_pipe;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_sub;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_ovf;
  logic             o_zero;

  int   checks   = 0;
  int   errors   = 0;
  int   accepted = 0;
  int   consumed = 0;
  res_t sb [$];

  bit          prev_stall = 0;
  logic [35:0] prev_out;

  addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_sub   (i_sub),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_cout  (o_cout),
    .o_ovf   (o_ovf),
    .o_zero  (o_zero)
  );

  always #5 i_clk = ~i_clk;

  // Reference: wide add, overflow judged from operand/result signs.
  function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [32:0] full;
    logic [31:0] bb;
    res_t        r;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + 33'(sub);
    r.sum  = full[31:0];
    r.cout = full[32] ^ sub;
    if (sub) r.ovf = (a[31] != b[31]) && (r.sum[31] != a[31]);
    else     r.ovf = (a[31] == b[31]) && (r.sum[31] != a[31]);
    r.zero = (r.sum == 32'h0);
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Scoreboard and stall monitor, sampled mid-cycle where inputs are stable.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check_output("stall hold sum", o_sum, prev_out[31:0]);
        check_output("stall hold flags", {28'h0, o_valid, o_cout, o_ovf, o_zero}, {28'h0, prev_out[35:32]});
      end
      if (i_valid && o_ready) begin
        sb.push_back(ref_model(i_a, i_b, i_sub));
        accepted++;
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb unexpected: got output %h, expected no output", o_sum);
        end else begin
          res_t e;
          e = sb.pop_front();
          check_output("sb sum", o_sum, e.sum);
          check_output("sb flags", {29'h0, o_cout, o_ovf, o_zero}, {29'h0, e.cout, e.ovf, e.zero});
        end
        consumed++;
      end
      prev_stall = o_valid && !i_ready;
      prev_out   = {o_valid, o_cout, o_ovf, o_zero, o_sum};
    end
  end

  // Offer one op and hold it until accepted; returns 1ns after the accept edge.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic sub);
    bit done;
    done    = 0;
    i_valid = 1'b1;
    i_a     = a;
    i_b     = b;
    i_sub   = sub;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge i_clk);
      done = o_ready;
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    if (!done) report_timeout("apply_stimulus accept");
  endtask

  // Single op with an idle pipe: o_valid must rise exactly STAGES cycles on.
  task automatic run_directed(input string name, input vec_t v);
    i_ready = 1'b1;
    apply_stimulus(v.a, v.b, v.sub);
    repeat (STAGES-2) @(posedge i_clk);
    #1;
    check_output({name, " early valid"}, {31'h0, o_valid}, 32'h0);
    @(posedge i_clk);
    #1;
    check_output({name, " valid"}, {31'h0, o_valid}, 32'h1);
    check_output({name, " sum"}, o_sum, v.sum);
    check_output({name, " cout"}, {31'h0, o_cout}, {31'h0, v.cout});
    check_output({name, " ovf"}, {31'h0, o_ovf}, {31'h0, v.ovf});
    check_output({name, " zero"}, {31'h0, o_zero}, {31'h0, v.zero});
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    vec_t vecs [7];
    vec_t v;
    int   start;
    int   cyc;
    int   guard;
    bit   vt;

    vecs[0] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0};

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_a     = '0;
    i_b     = '0;
    i_sub   = 1'b0;

    #1;
    check_output("reset valid", {31'h0, o_valid}, 32'h0);
    check_output("reset sum", o_sum, 32'h0);
    check_output("reset flags", {29'h0, o_cout, o_ovf, o_zero}, 32'h0);
    #20;
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    #1 check_output("reset ready", {31'h0, o_ready}, 32'h1);
    @(posedge i_clk);
    #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      run_directed($sformatf("vec%0d", i), v);
    end

    $display("[TB] backpressure");
    start = consumed;
    fork
      begin
        for (int i = 0; i < 6; i++)
          apply_stimulus(32'h1000_0000 * i + 32'h0101, 32'h0000_F0F0 + i, 1'(i % 2));
      end
      begin
        guard = 0;
        while (!o_valid && guard < 50) begin
          @(posedge i_clk);
          #1;
          guard++;
        end
        if (!o_valid) report_timeout("bp first output");
        i_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge i_clk);
          check_output("bp ready low", {31'h0, o_ready}, 32'h0);
          @(posedge i_clk);
          #1;
        end
        i_ready = 1'b1;
        for (int s = 0; s < 6; s++) begin
          @(negedge i_clk);
          check_output("bp drain valid", {31'h0, o_valid}, 32'h1);
          @(posedge i_clk);
          #1;
        end
      end
    join
    check_output("bp consumed", consumed - start, 6);
    check_output("bp idle", {31'h0, o_valid}, 32'h0);

    $display("[TB] reset mid-stream");
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) apply_stimulus(32'h0000_0010 + i, 32'h0000_0020, 1'b0);
    guard = 0;
    while (!o_valid && guard < 20) begin
      @(posedge i_clk);
      #1;
      guard++;
    end
    check_output("rst pre valid", {31'h0, o_valid}, 32'h1);
    #2 i_rst_n = 1'b0;
    sb.delete();
    #1;
    check_output("rst valid", {31'h0, o_valid}, 32'h0);
    check_output("rst sum", o_sum, 32'h0);
    check_output("rst flags", {29'h0, o_cout, o_ovf, o_zero}, 32'h0);
    @(negedge i_clk);
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    i_ready = 1'b1;
    #1 check_output("rst ready", {31'h0, o_ready}, 32'h1);
    for (int s = 0; s < 3; s++) begin
      @(negedge i_clk);
      check_output("rst quiet", {31'h0, o_valid}, 32'h0);
    end
    @(posedge i_clk);
    #1;
    v = '{32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b0};
    run_directed("rst new op", v);

    $display("[TB] random bubbles and backpressure");
    start = accepted;
    cyc   = 0;
    vt    = 1;
    while ((accepted - start) < 1000 && cyc < 20000) begin
      i_valid = vt;
      vt      = ~vt;
      i_a     = pick_operand();
      i_b     = pick_operand();
      i_sub   = 1'($urandom_range(0, 1));
      i_ready = 1'($urandom_range(0, 1));
      @(posedge i_clk);
      #1;
      cyc++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    if ((accepted - start) < 1000) report_timeout("random accept");
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge i_clk);
      #1;
      guard++;
    end
    if (sb.size() != 0) report_timeout("random drain");
    check_output("random idle", {31'h0, o_valid}, 32'h0);
    check_output("scoreboard empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
